mem_master_port: RTL

MEM_MASTER_PORT -- requirements
Module: mem_master_port

---
 rtl/mem_master_port.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_master_port.sv
// Burst master between a command/stream interface and a simple single-port memory.
// Write beats go straight to memory; read beats are fetched one at a time and held until consumed.
module mem_master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  wen,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rvalid
);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RD_OUT, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] acnt;
  logic [LEN_WIDTH-1:0]  rcnt;
  logic [ADDR_WIDTH-1:0] anext;
  logic                  last;

  assign anext     = acnt + ADDR_WIDTH'(1);
  assign last      = (rcnt == LEN_WIDTH'(1));
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign din_ready = (state == WR);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      acnt       <= '0;
      rcnt       <= '0;
      addr       <= '0;
      wdata      <= '0;
      dout       <= '0;
      wen        <= 1'b0;
      ren        <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      wen  <= 1'b0;
      ren  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            acnt <= cmd_addr;
            rcnt <= cmd_len;
            if (cmd_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (cmd_rw) begin
              state <= WR;
            end else begin
              // read request is issued as we enter RD_REQ so ren is a clean register
              state <= RD_REQ;
              ren   <= 1'b1;
              addr  <= cmd_addr;
            end
          end
        end
        WR: begin
          if (din_valid) begin
            wen   <= 1'b1;
            addr  <= acnt;
            wdata <= din;
            acnt  <= anext;
            rcnt  <= rcnt - LEN_WIDTH'(1);
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          if (rvalid) begin
            dout       <= rdata;
            dout_valid <= 1'b1;
            state      <= RD_OUT;
          end
        end
        RD_OUT: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            acnt       <= anext;
            rcnt       <= rcnt - LEN_WIDTH'(1);
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RD_REQ;
              ren   <= 1'b1;
              addr  <= anext;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
